tick_sched: RTL

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched_pkg.sv | 22 ++
 rtl/tick_chan.sv | 58 +++++
 rtl/tick_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_sched_pkg : shared defaults and FSM encoding for tick_sched      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tick_sched_pkg;

  localparam int c_nch_default        = 4;
  localparam int c_pw_default         = 6;
  localparam int c_def_period_default = 20;

  typedef logic [0:0] state_t;
  localparam state_t c_st_idle = 1'b0;
  localparam state_t c_st_busy = 1'b1;

  // Fold an index that overshot n by at most one lap back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_chan : one periodic channel (counter, period, pending, overrun) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_chan #(
  parameter int PW         = 6,
  parameter int DEF_PERIOD = 20
)(
  input  logic          clk_1ms,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_period,
  input  logic          take,
  output logic          pending,
  output logic          overrun
);

  logic [PW-1:0] r_count;
  logic [PW-1:0] r_period;
  logic          r_pending;
  logic          r_overrun;
  logic          w_expire;

  assign w_expire = (r_period != '0) && (r_count == r_period - PW'(1));

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      r_count   <= '0;
      r_period  <= PW'(DEF_PERIOD);
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (cfg_we) begin
      r_period  <= cfg_period;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if ((r_period == '0) || w_expire)
        r_count <= '0;
      else
        r_count <= r_count + PW'(1);
      // A job being granted on this very edge is not a missed deadline.
      if (w_expire) begin
        r_pending <= 1'b1;
        if (r_pending && !take)
          r_overrun <= 1'b1;
      end else if (take) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/tick_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_sched : periodic channels with round-robin one-hot task grant   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NCH        = c_nch_default,
  parameter int PW         = c_pw_default,
  parameter int DEF_PERIOD = c_def_period_default,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
)(
  input  logic           clk_1ms,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           task_done,
  output logic [NCH-1:0] grant,
  output logic           grant_valid,
  output logic [NCH-1:0] overrun
);

  state_t         r_state;
  state_t         w_state_next;
  logic [NCH-1:0] w_pending;
  logic [NCH-1:0] w_take_vec;
  logic [NCH-1:0] r_grant;
  logic           r_grant_valid;
  logic [CW-1:0]  r_ptr;
  logic [CW-1:0]  r_gidx;
  logic [CW-1:0]  w_pick;
  logic [CW-1:0]  w_cand;
  logic           w_found;
  logic           w_take;
  logic           w_release;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    tick_chan #(
      .PW         (PW),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_chan (
      .clk_1ms    (clk_1ms),
      .reset      (reset),
      .cfg_we     (cfg_we && (cfg_ch == CW'(gi))),
      .cfg_period (cfg_period),
      .take       (w_take_vec[gi]),
      .pending    (w_pending[gi]),
      .overrun    (overrun[gi])
    );
  end

  // First pending channel at or after ptr, scanning upward with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = CW'(rr_wrap(int'(r_ptr) + k, NCH));
      if (!w_found && w_pending[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (reset)
      r_state <= c_st_idle;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_found)   w_state_next = c_st_busy;
      c_st_busy: if (task_done) w_state_next = c_st_idle;
      default:                  w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_take     = (r_state == c_st_idle) && w_found;
    w_release  = (r_state == c_st_busy) && task_done;
    w_take_vec = w_take ? (NCH'(1) << w_pick) : '0;
  end

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_gidx        <= '0;
      r_ptr         <= '0;
    end else if (w_take) begin
      r_grant       <= w_take_vec;
      r_grant_valid <= 1'b1;
      r_gidx        <= w_pick;
    end else if (w_release) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= (r_gidx == CW'(NCH - 1)) ? '0 : r_gidx + CW'(1);
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;

endmodule
`default_nettype wire
